// File: rtl/alarm_ctrl_if.sv
// Alarm controller bus: running time, user pulses in; alarm digits, ring and tone out.
interface alarm_ctrl_if;
  localparam int unsigned TW = 6;

  logic [TW-1:0] i_hr;
  logic [TW-1:0] i_min;
  logic [TW-1:0] i_sec;
  logic          i_set_pos;
  logic          i_set_inc;
  logic          i_alarm_tgl;
  logic          i_stop;
  logic          i_snooze;
  logic [TW-1:0] o_alm_hr;
  logic [TW-1:0] o_alm_min;
  logic          o_alarm_en;
  logic          o_ringing;
  logic          o_buzz;

  // Time source / user panel side
  modport master (
    output i_hr, i_min, i_sec, i_set_pos, i_set_inc, i_alarm_tgl, i_stop, i_snooze,
    input  o_alm_hr, o_alm_min, o_alarm_en, o_ringing, o_buzz
  );

  // Alarm controller side
  modport slave (
    input  i_hr, i_min, i_sec, i_set_pos, i_set_inc, i_alarm_tgl, i_stop, i_snooze,
    output o_alm_hr, o_alm_min, o_alarm_en, o_ringing, o_buzz
  );
endinterface

// File: rtl/alarm_ctrl.sv
// Alarm stage: holds the alarm time, detects the alarm minute from the running
// clock, and runs the ring/snooze sequence with a square-wave buzzer tone.
module alarm_ctrl #(
  parameter int unsigned TONE_DIV   = 25000,
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned SNOOZE_SEC = 300,
  parameter int unsigned MAX_SNOOZE = 3
) (
  input  logic       clk,
  input  logic       rst,
  alarm_ctrl_if.slave bus
);

  localparam int unsigned TW      = 6;
  localparam int unsigned SEC_MAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
  localparam int unsigned SEC_W   = (SEC_MAX > 1) ? $clog2(SEC_MAX) : 1;
  localparam int unsigned SNZ_W   = ($clog2(MAX_SNOOZE + 1) > 2) ? $clog2(MAX_SNOOZE + 1) : 2;
  localparam int unsigned TONE_W  = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RING   = 2'd1,
    S_SNOOZE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [TW-1:0]     prev_sec_q;
  logic [TW-1:0]     alm_hr_q, alm_hr_d;
  logic [TW-1:0]     alm_min_q, alm_min_d;
  logic              en_q, en_d;
  logic [SEC_W-1:0]  ring_cnt_q, ring_cnt_d;
  logic [SEC_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [SNZ_W-1:0]  snz_cnt_q, snz_cnt_d;
  logic [TONE_W-1:0] tone_cnt_q, tone_cnt_d;
  logic              buzz_q, buzz_d;
  logic              ringing_q, ringing_d;
  logic              sec_evt;
  logic              match;

  // Second boundary and alarm-minute detection from the running time
  assign sec_evt = (bus.i_sec != prev_sec_q);
  assign match   = en_q & sec_evt & (bus.i_sec == '0)
                 & (bus.i_min == alm_min_q) & (bus.i_hr == alm_hr_q);

  // Next-state: alarm setting, enable, ring/snooze sequencing and tone
  always_comb begin
    state_d    = state_q;
    alm_hr_d   = alm_hr_q;
    alm_min_d  = alm_min_q;
    en_d       = en_q;
    ring_cnt_d = ring_cnt_q;
    wait_cnt_d = wait_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    tone_cnt_d = '0;
    buzz_d     = 1'b0;

    if (bus.i_set_inc) begin
      if (bus.i_set_pos) begin
        alm_hr_d = (alm_hr_q == TW'(23)) ? '0 : alm_hr_q + TW'(1);
      end else begin
        alm_min_d = (alm_min_q == TW'(59)) ? '0 : alm_min_q + TW'(1);
      end
    end

    if (bus.i_alarm_tgl) begin
      en_d = ~en_q;
    end

    if (bus.i_alarm_tgl && en_q) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (match) begin
            state_d    = S_RING;
            ring_cnt_d = '0;
            snz_cnt_d  = '0;
          end
        end
        S_RING: begin
          if (bus.i_stop) begin
            state_d = S_IDLE;
          end else if (bus.i_snooze && (snz_cnt_q < SNZ_W'(MAX_SNOOZE))) begin
            state_d    = S_SNOOZE;
            wait_cnt_d = '0;
            snz_cnt_d  = snz_cnt_q + SNZ_W'(1);
          end else if (sec_evt) begin
            if (ring_cnt_q == SEC_W'(RING_SEC - 1)) begin
              state_d = S_IDLE;
            end else begin
              ring_cnt_d = ring_cnt_q + SEC_W'(1);
            end
          end
        end
        S_SNOOZE: begin
          if (bus.i_stop) begin
            state_d = S_IDLE;
          end else if (sec_evt) begin
            if (wait_cnt_q == SEC_W'(SNOOZE_SEC - 1)) begin
              state_d    = S_RING;
              ring_cnt_d = '0;
            end else begin
              wait_cnt_d = wait_cnt_q + SEC_W'(1);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Tone runs only while staying in RING; any entry restarts it from silence
    if ((state_d == S_RING) && (state_q == S_RING)) begin
      if (tone_cnt_q == TONE_W'(TONE_DIV - 1)) begin
        tone_cnt_d = '0;
        buzz_d     = ~buzz_q;
      end else begin
        tone_cnt_d = tone_cnt_q + TONE_W'(1);
        buzz_d     = buzz_q;
      end
    end

    ringing_d = (state_d == S_RING);
  end

  // State and output registers; prev_sec tracks i_sec even in reset
  always_ff @(posedge clk) begin
    prev_sec_q <= bus.i_sec;
    if (rst) begin
      state_q    <= S_IDLE;
      alm_hr_q   <= '0;
      alm_min_q  <= '0;
      en_q       <= 1'b0;
      ring_cnt_q <= '0;
      wait_cnt_q <= '0;
      snz_cnt_q  <= '0;
      tone_cnt_q <= '0;
      buzz_q     <= 1'b0;
      ringing_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      alm_hr_q   <= alm_hr_d;
      alm_min_q  <= alm_min_d;
      en_q       <= en_d;
      ring_cnt_q <= ring_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
      tone_cnt_q <= tone_cnt_d;
      buzz_q     <= buzz_d;
      ringing_q  <= ringing_d;
    end
  end

  assign bus.o_alm_hr   = alm_hr_q;
  assign bus.o_alm_min  = alm_min_q;
  assign bus.o_alarm_en = en_q;
  assign bus.o_ringing  = ringing_q;
  assign bus.o_buzz     = buzz_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Scoreboard bench for alarm_ctrl: directed scenarios plus randomized traffic,
// expected outputs from a seconds-remaining / cycles-in-ring reference model.
module tb_alarm_ctrl;

  localparam int TONE_DIV   = 4;
  localparam int RING_SEC   = 3;
  localparam int SNOOZE_SEC = 2;
  localparam int MAX_SNOOZE = 1;

  localparam int M_QUIET  = 0;
  localparam int M_RING   = 1;
  localparam int M_SNOOZE = 2;

  typedef struct packed {
    logic [5:0] hr;
    logic [5:0] mn;
    logic       en;
    logic       ring;
    logic       buzz;
  } exp_t;

  logic clk;
  logic rst;
  alarm_ctrl_if bus ();

  alarm_ctrl #(
    .TONE_DIV  (TONE_DIV),
    .RING_SEC  (RING_SEC),
    .SNOOZE_SEC(SNOOZE_SEC),
    .MAX_SNOOZE(MAX_SNOOZE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  int t_hr, t_min, t_sec;

  // reference model state
  int m_hr, m_min, m_prev, m_mode, m_left, m_snz_left, m_rcyc;
  bit m_en;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string name, int got, int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endfunction

  // Monitor: each negedge the outputs of the last edge are compared with the oldest expectation
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      chk("sb_alm_hr",  int'(bus.o_alm_hr),   int'(mon_e.hr));
      chk("sb_alm_min", int'(bus.o_alm_min),  int'(mon_e.mn));
      chk("sb_en",      int'(bus.o_alarm_en), int'(mon_e.en));
      chk("sb_ringing", int'(bus.o_ringing),  int'(mon_e.ring));
      chk("sb_buzz",    int'(bus.o_buzz),     int'(mon_e.buzz));
    end
  end

  // One clock: drive inputs, advance the reference model, queue its prediction
  task automatic step(input bit r, input bit pos, input bit inc, input bit tgl,
                      input bit stp, input bit snz);
    exp_t e;
    bit   evt;
    bit   hit;
    @(negedge clk);
    #1;
    rst             = r;
    bus.i_hr        = 6'(t_hr);
    bus.i_min       = 6'(t_min);
    bus.i_sec       = 6'(t_sec);
    bus.i_set_pos   = pos;
    bus.i_set_inc   = inc;
    bus.i_alarm_tgl = tgl;
    bus.i_stop      = stp;
    bus.i_snooze    = snz;

    evt    = (t_sec != m_prev);
    hit    = m_en && evt && (t_sec == 0) && (t_min == m_min) && (t_hr == m_hr);
    m_prev = t_sec;
    if (r) begin
      m_hr = 0; m_min = 0; m_en = 1'b0; m_mode = M_QUIET; m_rcyc = 0;
    end else begin
      if (tgl && m_en) begin
        m_mode = M_QUIET;
      end else if (m_mode == M_QUIET) begin
        if (hit) begin
          m_mode = M_RING; m_left = RING_SEC; m_snz_left = MAX_SNOOZE; m_rcyc = 0;
        end
      end else if (m_mode == M_RING) begin
        if (stp) m_mode = M_QUIET;
        else if (snz && m_snz_left > 0) begin
          m_mode = M_SNOOZE; m_left = SNOOZE_SEC; m_snz_left--;
        end else begin
          m_rcyc++;
          if (evt) begin
            m_left--;
            if (m_left == 0) m_mode = M_QUIET;
          end
        end
      end else begin
        if (stp) m_mode = M_QUIET;
        else if (evt) begin
          m_left--;
          if (m_left == 0) begin
            m_mode = M_RING; m_left = RING_SEC; m_rcyc = 0;
          end
        end
      end
      if (inc) begin
        if (pos) m_hr = (m_hr + 1) % 24;
        else     m_min = (m_min + 1) % 60;
      end
      if (tgl) m_en = !m_en;
    end

    e.hr   = 6'(m_hr);
    e.mn   = 6'(m_min);
    e.en   = m_en;
    e.ring = (m_mode == M_RING);
    e.buzz = (m_mode == M_RING) && (((m_rcyc / TONE_DIV) % 2) == 1);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic adv_sec();
    t_sec = (t_sec + 1) % 60;
    idle(1);
  endtask

  // Walk the clock 01:00:59 -> 01:01:00 so an armed 01:01 alarm fires on the last edge
  task automatic trigger();
    t_hr = 1; t_min = 0; t_sec = 59;
    idle(2);
    t_min = 1; t_sec = 0;
    idle(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int dr;
    rst = 1'b1;
    bus.i_hr = '0; bus.i_min = '0; bus.i_sec = '0;
    bus.i_set_pos = 1'b0; bus.i_set_inc = 1'b0; bus.i_alarm_tgl = 1'b0;
    bus.i_stop = 1'b0; bus.i_snooze = 1'b0;
    t_hr = 0; t_min = 0; t_sec = 0;
    m_hr = 0; m_min = 0; m_prev = 0; m_en = 1'b0; m_mode = M_QUIET;
    m_left = 0; m_snz_left = 0; m_rcyc = 0;

    // reset
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_alm_hr",  int'(bus.o_alm_hr), 0);
    chk("rst_alm_min", int'(bus.o_alm_min), 0);
    chk("rst_en",      int'(bus.o_alarm_en), 0);
    chk("rst_ringing", int'(bus.o_ringing), 0);
    chk("rst_buzz",    int'(bus.o_buzz), 0);

    // setting with wrap, no carry into hour
    repeat (61) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("set_min_wrap", int'(bus.o_alm_min), 1);
    chk("set_min_nocarry", int'(bus.o_alm_hr), 0);
    repeat (25) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("set_hr_wrap", int'(bus.o_alm_hr), 1);

    // trigger, tone cadence, timeout
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("arm_en", int'(bus.o_alarm_en), 1);
    trigger();
    chk("trig_ring", int'(bus.o_ringing), 1);
    chk("trig_buzz0", int'(bus.o_buzz), 0);
    idle(3);
    chk("buzz_before_div", int'(bus.o_buzz), 0);
    idle(1);
    chk("buzz_first_toggle", int'(bus.o_buzz), 1);
    idle(4);
    chk("buzz_second_toggle", int'(bus.o_buzz), 0);
    repeat (2) begin adv_sec(); idle(2); end
    chk("ring_before_timeout", int'(bus.o_ringing), 1);
    adv_sec();
    chk("ring_timeout", int'(bus.o_ringing), 0);
    chk("buzz_after_timeout", int'(bus.o_buzz), 0);

    // disabled alarm never rings; enabling at second 0 is not an event
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("disarm_en", int'(bus.o_alarm_en), 0);
    trigger();
    idle(2);
    chk("disabled_no_ring", int'(bus.o_ringing), 0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);
    chk("late_enable_en", int'(bus.o_alarm_en), 1);
    chk("late_enable_no_ring", int'(bus.o_ringing), 0);

    // snooze, re-ring, exhausted snooze ignored, stop
    trigger();
    chk("snz_trig", int'(bus.o_ringing), 1);
    idle(5);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("snz_silent", int'(bus.o_ringing), 0);
    chk("snz_buzz", int'(bus.o_buzz), 0);
    adv_sec();
    chk("snz_wait", int'(bus.o_ringing), 0);
    adv_sec();
    chk("snz_rering", int'(bus.o_ringing), 1);
    idle(2);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("snz_exhausted", int'(bus.o_ringing), 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("stop_ring", int'(bus.o_ringing), 0);

    // stop beats snooze; disable during snooze
    trigger();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("prio_stop", int'(bus.o_ringing), 0);
    repeat (3) adv_sec();
    chk("prio_stop_no_rering", int'(bus.o_ringing), 0);
    trigger();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("tgl_snooze_en", int'(bus.o_alarm_en), 0);
    repeat (2) adv_sec();
    chk("tgl_snooze_no_ring", int'(bus.o_ringing), 0);

    // reset while ringing, second held at 0 afterwards
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    trigger();
    chk("rr_ring", int'(bus.o_ringing), 1);
    idle(5);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rr_ringing", int'(bus.o_ringing), 0);
    chk("rr_buzz", int'(bus.o_buzz), 0);
    chk("rr_en", int'(bus.o_alarm_en), 0);
    chk("rr_alm_hr", int'(bus.o_alm_hr), 0);
    chk("rr_alm_min", int'(bus.o_alm_min), 0);
    idle(5);
    chk("rr_no_ring", int'(bus.o_ringing), 0);

    // randomized traffic; the clock often lands on the model's alarm time
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    t_sec = 50;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        if (t_sec == 59) begin
          t_sec = 0;
          if ($urandom_range(0, 1) == 0) begin
            t_hr = m_hr; t_min = m_min;
          end else begin
            t_hr = int'($urandom_range(0, 23)); t_min = int'($urandom_range(0, 59));
          end
        end else if (t_sec < 55) begin
          t_sec = 55;
        end else begin
          t_sec = t_sec + 1;
        end
      end
      step(($urandom_range(0, 999) == 0),
           ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 59) == 0),
           ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 19) == 0));
    end

    // let the monitor drain the scoreboard, bounded
    dr = 0;
    while (sb_q.size() > 0 && dr < 10) begin
      @(posedge clk);
      dr++;
    end
    chk("sb_drain", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
